// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry layout
// and fetch defaults.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP_REQ,
        DROP
    } fetch_state_t;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with push/pop/flush; flush beats push, pop on empty
// is ignored, and push on full is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [63:0]                wdata,
    output logic [63:0]                rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_COUNT) || do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !(reset || flush)) mem[wr_ptr] <= fetch_entry_t'(wdata);
    end

    always_comb begin
        rdata = '0;
        if (count != '0) rdata = 64'(mem[rd_ptr]);
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem handshake and an
// instruction queue for ID. Optional FETCH_STATS_EN adds flush/stall counters.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc4,
    output logic [31:0] out_ir,
    input  logic        out_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_flush,
    output logic [15:0] stat_stall
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEPTH - 1);

    fetch_state_t  state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   hold_pc, hold_pc_next;
    logic          pending, pending_next;
    logic          push, flush, pop;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic [31:0]   redirect_target;
    logic [31:0]   pc_step;
    logic          idle_credit, wait_credit;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({fetch_pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    assign out_valid = (count != '0);
    assign out_pc4   = head[63:32];
    assign out_ir    = head[31:0];
    assign pop       = out_valid && out_ready;

    always_comb begin
        redirect_target = redirect_pc & ~32'h3;
        pc_step         = fetch_pc + 32'(WORD_BYTES);
        idle_credit     = (count < FULL_COUNT);
        // Credit after this cycle's push: the request slot frees as the word lands.
        wait_credit     = pop || (count < LAST_COUNT);
    end

    // fetch_pc is bumped at grant, so in WAIT it already equals request PC + 4.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        hold_pc_next  = hold_pc;
        pending_next  = pending;
        push          = 1'b0;
        flush         = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = fetch_pc;

        case (state)
            IDLE: if (idle_credit) state_next = REQ;
            REQ: begin
                imem_req = !pending;
                if (pending) begin
                    if (imem_rvalid) pending_next = 1'b0;
                end else if (imem_gnt) begin
                    state_next    = WAIT;
                    fetch_pc_next = pc_step;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    state_next = wait_credit ? REQ : IDLE;
                end
            end
            DROP_REQ: begin
                imem_req  = 1'b1;
                imem_addr = hold_pc;
                if (imem_gnt) state_next = DROP;
            end
            DROP: if (imem_rvalid) state_next = REQ;
            default: state_next = IDLE;
        endcase

        // A response owed by a killed request is absorbed by DROP/DROP_REQ, or by
        // the pending flag when the redirect lands while already dropping.
        if (redirect_valid) begin
            flush         = 1'b1;
            push          = 1'b0;
            fetch_pc_next = redirect_target;
            case (state)
                REQ: begin
                    if (pending) begin
                        state_next   = REQ;
                        pending_next = !imem_rvalid;
                    end else if (imem_gnt) begin
                        state_next = DROP;
                    end else begin
                        state_next   = DROP_REQ;
                        hold_pc_next = fetch_pc;
                    end
                end
                WAIT:     state_next = imem_rvalid ? REQ : DROP;
                DROP_REQ: state_next = imem_gnt ? DROP : DROP_REQ;
                DROP: begin
                    state_next   = REQ;
                    pending_next = !imem_rvalid;
                end
                default:  state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC & ~32'h3;
            hold_pc  <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            hold_pc  <= hold_pc_next;
            pending  <= pending_next;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_flush <= '0;
            stat_stall <= '0;
        end else begin
            if (redirect_valid && (stat_flush != '1))     stat_flush <= stat_flush + 16'd1;
            if (out_valid && !out_ready && (stat_stall != '1)) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a scripted imem responder (grant gating,
// response latency, one-address data override). Stats test runs when FETCH_STATS_EN is set.
module tb_if_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc4;
    logic [31:0] out_ir;
    logic        out_ready;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_flush;
    logic [15:0] stat_stall;
`endif

    int checks = 0;
    int passes = 0;

    bit          gnt_en = 1'b1;
    int          rlat = 1;
    bit          use_override = 1'b0;
    logic [31:0] override_addr = '0;
    logic [31:0] override_word = '0;
    int          fire_count = 0;
    int          resp_cnt = 0;
    logic [31:0] resp_word = '0;

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc4        (out_pc4),
        .out_ir         (out_ir),
        .out_ready      (out_ready)
`ifdef FETCH_STATS_EN
        ,
        .stat_flush     (stat_flush),
        .stat_stall     (stat_stall)
`endif
    );

    always #5 clock = ~clock;

    assign imem_gnt = imem_req & gnt_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge clock) begin
        logic        f;
        logic [31:0] a;
        f = imem_req && imem_gnt;
        a = imem_addr;
        #1;
        imem_rvalid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = resp_word;
            end
        end
        if (f) begin
            fire_count = fire_count + 1;
            resp_word  = (use_override && a == override_addr) ? override_word : mem_word(a);
            if (rlat <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = resp_word;
            end else begin
                resp_cnt = rlat - 1;
            end
        end
    end

    // Leaves the bench at the negedge of cycle 0 (first cycle whose edge sees reset low).
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passes++;
        checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", imem_addr); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_pc4 !== 32'h0) $display("FAIL reset_pc4: got %h want 00000000", out_pc4); else passes++;
        checks++; if (out_ir !== 32'h0) $display("FAIL reset_ir: got %h want 00000000", out_ir); else passes++;
    endtask

    task automatic test_stream();
        logic        exp_req  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        logic [31:0] exp_addr [8] = '{0, 32'h0, 0, 32'h4, 0, 32'h8, 0, 32'hC};
        logic        exp_ov   [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
        logic [31:0] exp_pc4  [8] = '{0, 0, 0, 32'h4, 0, 32'h8, 0, 32'hC};
        out_ready = 1'b1; gnt_en = 1'b1; rlat = 1; use_override = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clock);
            checks++;
            if (imem_req !== exp_req[c]) $display("FAIL stream_req c%0d: got %b want %b", c, imem_req, exp_req[c]);
            else passes++;
            if (exp_req[c]) begin
                checks++;
                if (imem_addr !== exp_addr[c]) $display("FAIL stream_addr c%0d: got %h want %h", c, imem_addr, exp_addr[c]);
                else passes++;
            end
            checks++;
            if (out_valid !== exp_ov[c]) $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, exp_ov[c]);
            else passes++;
            if (exp_ov[c]) begin
                checks++;
                if (out_pc4 !== exp_pc4[c] || out_ir !== mem_word(exp_pc4[c] - 32'h4))
                    $display("FAIL stream_head c%0d: got %h/%h want %h/%h", c, out_pc4, out_ir,
                             exp_pc4[c], mem_word(exp_pc4[c] - 32'h4));
                else passes++;
            end
        end
    endtask

    task automatic test_backpressure();
        int          fire0;
        int          late_req;
        logic [31:0] exp_pop [3] = '{32'h8, 32'hC, 32'h10};
        out_ready = 1'b0; gnt_en = 1'b1; rlat = 1; use_override = 1'b0;
        do_reset();
        fire0    = fire_count;
        late_req = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c >= 10 && imem_req) late_req++;
        end
        checks++; if (fire_count - fire0 != 4) $display("FAIL bp_grants: got %0d want 4", fire_count - fire0); else passes++;
        checks++; if (late_req != 0) $display("FAIL bp_req_idle: got %0d req cycles want 0", late_req); else passes++;
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h4) $display("FAIL bp_head: got %b/%h want 1/00000004", out_valid, out_pc4);
        else passes++;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_pc4 !== exp_pop[j]) $display("FAIL bp_pop%0d: got %b/%h want 1/%h", j, out_valid, out_pc4, exp_pop[j]);
            else passes++;
            if (j == 1) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL bp_resume: got %b/%h want 1/00000010", imem_req, imem_addr);
                else passes++;
            end
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h14 || out_ir !== mem_word(32'h10))
            $display("FAIL bp_wrap: got %b/%h/%h want 1/00000014/%h", out_valid, out_pc4, out_ir, mem_word(32'h10));
        else passes++;
    endtask

    task automatic test_redirect_wait();
        int n;
        out_ready = 1'b1; gnt_en = 1'b1; rlat = 2;
        use_override = 1'b1; override_addr = 32'h0; override_word = 32'hDEADBEEF;
        do_reset();
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rw_req: got %b/%h want 1/00000000", imem_req, imem_addr); else passes++;
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) $display("FAIL rw_wait: got req %b want 0", imem_req); else passes++;
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL rw_flush: got %b want 0", out_valid); else passes++;
        n = 0;
        while (!imem_req && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rw_refetch: got %b/%h want 1/00000040", imem_req, imem_addr);
        else passes++;
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h44 || out_ir !== mem_word(32'h40))
            $display("FAIL rw_head: got %b/%h/%h want 1/00000044/%h", out_valid, out_pc4, out_ir, mem_word(32'h40));
        else passes++;
        use_override = 1'b0;
    endtask

    task automatic test_redirect_req();
        int n;
        out_ready = 1'b1; gnt_en = 1'b0; rlat = 1; use_override = 1'b0;
        do_reset();
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rq_req: got %b/%h want 1/00000000", imem_req, imem_addr); else passes++;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rq_hold1: got %b/%h want 1/00000000", imem_req, imem_addr); else passes++;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rq_hold2: got %b/%h want 1/00000000", imem_req, imem_addr); else passes++;
        gnt_en = 1'b1;
        @(negedge clock);
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) $display("FAIL rq_drop: got req %b valid %b want 0/0", imem_req, out_valid); else passes++;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) $display("FAIL rq_target: got %b/%h want 1/00000080", imem_req, imem_addr); else passes++;
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h84 || out_ir !== mem_word(32'h80))
            $display("FAIL rq_head: got %b/%h/%h want 1/00000084/%h", out_valid, out_pc4, out_ir, mem_word(32'h80));
        else passes++;
    endtask

    task automatic test_redirect_pop();
        int n;
        out_ready = 1'b0; gnt_en = 1'b1; rlat = 1; use_override = 1'b0;
        do_reset();
        repeat (7) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h4 || imem_req !== 1'b1)
            $display("FAIL rp_fill: got %b/%h req %b want 1/00000004 req 1", out_valid, out_pc4, imem_req);
        else passes++;
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL rp_flush: got %b want 0", out_valid); else passes++;
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h104 || out_ir !== mem_word(32'h100))
            $display("FAIL rp_head: got %b/%h/%h want 1/00000104/%h", out_valid, out_pc4, out_ir, mem_word(32'h100));
        else passes++;
    endtask

    task automatic test_mid_reset();
        int n;
        out_ready = 1'b1; gnt_en = 1'b1; rlat = 2; use_override = 1'b0;
        do_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0)
            $display("FAIL mr_state: got %b/%h/%b want 0/00000000/0", imem_req, imem_addr, out_valid);
        else passes++;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0)
            $display("FAIL mr_refetch: got %b/%h/%b want 1/00000000/0", imem_req, imem_addr, out_valid);
        else passes++;
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'h4 || out_ir !== mem_word(32'h0))
            $display("FAIL mr_head: got %b/%h/%h want 1/00000004/%h", out_valid, out_pc4, out_ir, mem_word(32'h0));
        else passes++;
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        out_ready = 1'b1; gnt_en = 1'b1; rlat = 1; use_override = 1'b0;
        do_reset();
        checks++; if (stat_flush !== 16'h0 || stat_stall !== 16'h0) $display("FAIL st_init: got %h/%h want 0000/0000", stat_flush, stat_stall); else passes++;
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        repeat (5) @(negedge clock);
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clock);
        redirect_valid = 1'b0;
        @(negedge clock);
        redirect_valid = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b0;
        @(negedge clock);
        checks++; if (stat_flush !== 16'd2) $display("FAIL st_flush: got %0d want 2", stat_flush); else passes++;
        checks++; if (stat_stall !== 16'd5) $display("FAIL st_stall: got %0d want 5", stat_stall); else passes++;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (stat_flush !== 16'h0 || stat_stall !== 16'h0) $display("FAIL st_reset: got %h/%h want 0000/0000", stat_flush, stat_stall); else passes++;
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_pop();
        test_mid_reset();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
